// File: rtl/alu_sweep_if.sv
// Operand/opcode bus between the sweep driver and a combinational ALU.
interface alu_sweep_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_y;

  modport master (output alu_a, output alu_b, output alu_op, input alu_y);
  modport slave  (input alu_a, input alu_b, input alu_op, output alu_y);
endinterface

// File: rtl/alu_sweep_driver.sv
// Latches an operand pair on start, steps the ALU through all eight opcodes,
// reports each sampled result and folds it into a rotate-xor signature.
//
// state | meaning
// IDLE  | waiting for start after reset
// DRIVE | holding the current opcode, sampling after HOLD cycles
// DONE  | sweep finished, signature held until the next start
module alu_sweep_driver #(
  parameter int WIDTH = 8,
  parameter int HOLD  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  alu_sweep_if.master      alu,
  output logic             busy,
  output logic             res_valid,
  output logic [2:0]       res_op,
  output logic [WIDTH-1:0] res_y,
  output logic [WIDTH-1:0] sig,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  state_t     state;
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      alu.alu_a  <= '0;
      alu.alu_b  <= '0;
      alu.alu_op <= '0;
      busy       <= 1'b0;
      res_valid  <= 1'b0;
      res_op     <= '0;
      res_y      <= '0;
      sig        <= '0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          res_valid <= 1'b0;
          if (start) begin
            alu.alu_a  <= a_in;
            alu.alu_b  <= b_in;
            alu.alu_op <= '0;
            cnt        <= '0;
            sig        <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt == HOLD_LAST) begin
            cnt       <= '0;
            res_y     <= alu.alu_y;
            res_op    <= alu.alu_op;
            res_valid <= 1'b1;
            sig       <= {sig[WIDTH-2:0], sig[WIDTH-1]} ^ alu.alu_y;
            // Last opcode: leave alu_op parked at 7 so the bus stays stable.
            if (alu.alu_op == 3'd7) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              alu.alu_op <= alu.alu_op + 3'd1;
            end
          end else begin
            cnt       <= cnt + 8'd1;
            res_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sweep_driver.sv
// Bench for alu_sweep_driver: HOLD=4 and HOLD=1 instances share stimulus and
// are checked against directed vectors and a cycle-count reference model.
module tb_alu_sweep_driver;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;

  logic       busy4, rv4, done4, busy1, rv1, done1;
  logic [2:0] rop4, rop1;
  logic [7:0] ry4, sig4, ry1, sig1;

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  alu_sweep_if #(.WIDTH(8)) bus4 ();
  alu_sweep_if #(.WIDTH(8)) bus1 ();

  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input int op);
    logic [15:0] p;
    p = a * b;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return p[7:0];
      3: return (b == 8'd0) ? 8'hFF : a / b;
      4: return a & b;
      5: return a | b;
      6: return ~a;
      default: return a ^ b;
    endcase
  endfunction

  assign bus4.alu_y = ref_alu(bus4.alu_a, bus4.alu_b, int'(bus4.alu_op));
  assign bus1.alu_y = ref_alu(bus1.alu_a, bus1.alu_b, int'(bus1.alu_op));

  alu_sweep_driver #(.WIDTH(8), .HOLD(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .alu(bus4),
    .busy(busy4), .res_valid(rv4), .res_op(rop4), .res_y(ry4), .sig(sig4), .done(done4)
  );

  alu_sweep_driver #(.WIDTH(8), .HOLD(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .alu(bus1),
    .busy(busy1), .res_valid(rv1), .res_op(rop1), .res_y(ry1), .sig(sig1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: expected behaviour from elapsed cycles since the accepted start.
  logic       s_rst = 1'b0, s_start = 1'b0;
  logic [7:0] s_a = '0, s_b = '0;
  always @(posedge clk) begin
    s_rst   <= rst;
    s_start <= start;
    s_a     <= a_in;
    s_b     <= b_in;
  end

  bit         m_act[2]  = '{0, 0};
  bit         m_done[2] = '{0, 0};
  bit         m_rv[2]   = '{0, 0};
  int         m_t[2]    = '{0, 0};
  int         m_opi[2]  = '{0, 0};
  int         m_rop[2]  = '{0, 0};
  logic [7:0] m_a[2]    = '{0, 0};
  logic [7:0] m_b[2]    = '{0, 0};
  logic [7:0] m_ry[2]   = '{0, 0};
  logic [7:0] m_sig[2]  = '{0, 0};

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int h, k, e_op;
        h = (i == 0) ? 4 : 1;
        if (s_rst) begin
          m_act[i] = 0; m_done[i] = 0; m_rv[i] = 0; m_t[i] = 0; m_opi[i] = 0;
          m_rop[i] = 0; m_a[i] = 0; m_b[i] = 0; m_ry[i] = 0; m_sig[i] = 0;
        end else if (!m_act[i] && s_start) begin
          m_act[i] = 1; m_done[i] = 0; m_rv[i] = 0; m_t[i] = 0;
          m_a[i] = s_a; m_b[i] = s_b; m_sig[i] = 0;
        end else if (m_act[i]) begin
          m_t[i]++;
          m_rv[i] = (m_t[i] % h == 0);
          if (m_rv[i]) begin
            k = m_t[i] / h - 1;
            m_rop[i] = k;
            m_ry[i]  = ref_alu(m_a[i], m_b[i], k);
            m_sig[i] = {m_sig[i][6:0], m_sig[i][7]} ^ m_ry[i];
            if (k == 7) begin
              m_act[i] = 0; m_done[i] = 1; m_opi[i] = 7;
            end
          end
        end else begin
          m_rv[i] = 0;
        end
        e_op = m_act[i] ? m_t[i] / h : m_opi[i];
        if (mon_en) begin
          chk($sformatf("m%0d.busy", i),  (i == 0) ? busy4 : busy1, m_act[i]);
          chk($sformatf("m%0d.done", i),  (i == 0) ? done4 : done1, m_done[i]);
          chk($sformatf("m%0d.rv", i),    (i == 0) ? rv4 : rv1, m_rv[i]);
          chk($sformatf("m%0d.rop", i),   (i == 0) ? rop4 : rop1, m_rop[i]);
          chk($sformatf("m%0d.ry", i),    (i == 0) ? ry4 : ry1, m_ry[i]);
          chk($sformatf("m%0d.sig", i),   (i == 0) ? sig4 : sig1, m_sig[i]);
          chk($sformatf("m%0d.alu_a", i), (i == 0) ? bus4.alu_a : bus1.alu_a, m_a[i]);
          chk($sformatf("m%0d.alu_b", i), (i == 0) ? bus4.alu_b : bus1.alu_b, m_b[i]);
          chk($sformatf("m%0d.alu_op", i), (i == 0) ? bus4.alu_op : bus1.alu_op, e_op);
        end
      end
    end
  end

  typedef struct packed {
    logic [7:0]      a;
    logic [7:0]      b;
    logic [7:0]      rp;   // cycle offset of an extra start pulse (0 = none)
    logic [7:0][7:0] y;
    logic [7:0]      s;
  } vec_t;

  vec_t vecs[3];

  task automatic run_sweep(input vec_t v);
    int k4, k1;
    k4 = 0;
    k1 = 0;
    start = 1'b1; a_in = v.a; b_in = v.b;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("start.busy", busy4, 1);
    chk("start.done", done4, 0);
    chk("start.sig", sig4, 0);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); @(negedge clk);
      if (rv4) begin
        if (k4 < 8) begin
          chk("h4.edge", c, 4 * (k4 + 1));
          chk("h4.res_op", rop4, k4);
          chk("h4.res_y", ry4, v.y[k4]);
        end
        k4++;
      end
      if (v.rp == 8'd0 && rv1) begin
        if (k1 < 8) begin
          chk("h1.edge", c, k1 + 1);
          chk("h1.res_y", ry1, v.y[k1]);
        end
        k1++;
      end
      if (c == 32) begin
        chk("h4.done", done4, 1);
        chk("h4.busy", busy4, 0);
        chk("h4.sig", sig4, v.s);
      end
      if (v.rp == 8'd0 && c == 8) begin
        chk("h1.done", done1, 1);
        chk("h1.sig", sig1, v.s);
      end
      start = (v.rp != 8'd0 && c == int'(v.rp) - 1);
      if (start) a_in = 8'd9;
    end
    chk("h4.count", k4, 8);
    if (v.rp == 8'd0) chk("h1.count", k1, 8);
  endtask

  initial begin
    int seen;
    vecs[0].a = 8'd7;    vecs[0].b = 8'd3;    vecs[0].rp = 8'd0;
    vecs[0].y = {8'd4, 8'd248, 8'd7, 8'd3, 8'd2, 8'd21, 8'd4, 8'd10};
    vecs[0].s = 8'h77;
    vecs[1] = vecs[0];
    vecs[1].rp = 8'd10;
    vecs[2].a = 8'hFF;   vecs[2].b = 8'h01;   vecs[2].rp = 8'd0;
    vecs[2].y = {8'hFE, 8'h00, 8'hFF, 8'h01, 8'hFF, 8'hFF, 8'hFE, 8'h00};
    vecs[2].s = 8'hB6;

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    @(posedge clk);
    mon_en = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      chk("rst.busy", busy4 | busy1, 0);
      chk("rst.done", done4 | done1, 0);
      chk("rst.rv", rv4 | rv1, 0);
      chk("rst.y", ry4 | ry1 | sig4 | sig1, 0);
      chk("rst.bus", bus4.alu_a | bus4.alu_b | 8'(bus4.alu_op), 0);
    end

    for (int i = 0; i < 3; i++) run_sweep(vecs[i]);

    // Abort mid-sweep: reset sampled at edge N+13.
    start = 1'b1; a_in = 8'd7; b_in = 8'd3;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("abort.busy", busy4, 0);
    chk("abort.rv", rv4, 0);
    chk("abort.y", ry4 | sig4, 0);
    chk("abort.op", rop4 | bus4.alu_op, 0);
    chk("abort.bus", bus4.alu_a | bus4.alu_b, 0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); @(negedge clk);
      if (rv4 || done4) seen++;
    end
    chk("abort.quiet", seen, 0);
    run_sweep(vecs[0]);

    for (int c = 0; c < 800; c++) begin
      rst   = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 11) == 0);
      a_in  = 8'($urandom);
      b_in  = 8'($urandom);
      @(posedge clk); @(negedge clk);
    end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
